bpug_sequencer: RTL and testbench

// - Issue side of the BPU-group instruction interface. Pulls image/weight bytes from a valid/ready byte stream.
// - Emits the 13-bit instruction word, data byte, enable and sel that drive one BPU group through one layer tile.
// - Sequence: weight load -> image prime -> {compute, row shift-up, row reload} x rows.
// - Sits between the on-chip feature/weight buffer reader and the BPU group.

---
 rtl/bpug_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_bpug_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bpug_sequencer.sv
// Issue-side sequencer for one BPU group: weight load, image prime, then compute/shift/reload per row.
// Optional stall counter output perf_stall is built when BPUG_SEQ_PERF_EN is defined.
module bpug_sequencer #(
  parameter int NUM_BPU   = 8,
  parameter int WGT_BYTES = 7,
  parameter int CMP_CYC   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  cfg_rows,
  input  logic [4:0]  cfg_op,
  input  logic        cfg_sel,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [12:0] bpug_instr,
  output logic [7:0]  bpug_data,
  output logic        bpug_enable,
  output logic        bpug_sel,
  output logic        busy,
  output logic        done
`ifdef BPUG_SEQ_PERF_EN
  ,
  output logic [15:0] perf_stall
`endif
);

  localparam int CMP_W = (2 * CMP_CYC > 1) ? $clog2(2 * CMP_CYC) : 1;
  localparam logic [2:0]       K_LAST   = 3'(WGT_BYTES - 1);
  localparam logic [2:0]       B_LAST   = 3'(NUM_BPU - 1);
  localparam logic [2:0]       BYTE_LAST = 3'd7;
  localparam logic [CMP_W-1:0] CMP_LAST = CMP_W'(2 * CMP_CYC - 1);
  localparam logic [CMP_W-1:0] CMP_HALF = CMP_W'(CMP_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WGT,
    S_IMG_LO,
    S_IMG_HI,
    S_COMPUTE,
    S_UP,
    S_ROW
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       k_q;
  logic [2:0]       b_q;
  logic [2:0]       byte_q;
  logic [CMP_W-1:0] cmp_q;
  logic [5:0]       rows_q;
  logic [4:0]       op_q;

  logic        load_st;
  logic        take;
  logic        start_acc;
  logic        wgt_last;
  logic        byte_last;
  logic        cmp_last;
  logic        data_sel;

  logic [12:0] instr_d;
  logic [7:0]  data_d;
  logic        en_d;
  logic        done_d;

  assign load_st   = (state_q == S_WGT) || (state_q == S_IMG_LO) ||
                     (state_q == S_IMG_HI) || (state_q == S_ROW);
  assign s_ready   = load_st;
  assign take      = load_st && s_valid;
  assign start_acc = start && (state_q == S_IDLE) && !busy;
  assign wgt_last  = (b_q == B_LAST) && (k_q == K_LAST);
  assign byte_last = (byte_q == BYTE_LAST);
  assign cmp_last  = (cmp_q == CMP_LAST);
  assign data_sel  = (cmp_q >= CMP_HALF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_acc) state_d = S_WGT;
      S_WGT:     if (take && wgt_last) state_d = S_IMG_LO;
      S_IMG_LO:  if (take && byte_last) state_d = S_IMG_HI;
      S_IMG_HI:  if (take && byte_last) state_d = S_COMPUTE;
      S_COMPUTE: if (cmp_last) state_d = (rows_q == 6'd0) ? S_IDLE : S_UP;
      S_UP:      state_d = S_ROW;
      S_ROW:     if (take && byte_last) state_d = S_COMPUTE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Word to be presented on the next cycle; a stalled load state leaves it as an all-zero NOP.
  always_comb begin
    instr_d = 13'd0;
    data_d  = 8'd0;
    en_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_WGT: begin
        if (take) begin
          instr_d = {b_q, 1'b0, 1'b0, 2'b01, 1'b0, 5'd0};
          data_d  = s_data;
          en_d    = 1'b1;
        end
      end
      S_IMG_LO, S_ROW: begin
        if (take) begin
          instr_d = {3'd0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd0};
          data_d  = s_data;
          en_d    = 1'b1;
        end
      end
      S_IMG_HI: begin
        if (take) begin
          instr_d = {3'd0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd0};
          data_d  = s_data;
          en_d    = 1'b1;
        end
      end
      S_COMPUTE: begin
        instr_d = {3'd0, 1'b0, 1'b0, 2'b00, data_sel, op_q};
        en_d    = 1'b1;
        done_d  = cmp_last && (rows_q == 6'd0);
      end
      S_UP: begin
        instr_d = {3'd0, 1'b0, 1'b1, 2'b00, 1'b0, 5'd0};
        en_d    = 1'b1;
      end
      default: begin
        instr_d = 13'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bpug_instr  <= 13'd0;
      bpug_data   <= 8'd0;
      bpug_enable <= 1'b0;
      done        <= 1'b0;
    end else begin
      bpug_instr  <= instr_d;
      bpug_data   <= data_d;
      bpug_enable <= en_d;
      done        <= done_d;
    end
  end

  // busy and the group select stay up through the done cycle and drop on the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      bpug_sel <= 1'b0;
    end else if (start_acc) begin
      busy     <= 1'b1;
      bpug_sel <= cfg_sel;
    end else if (done) begin
      busy     <= 1'b0;
      bpug_sel <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q    <= 3'd0;
      b_q    <= 3'd0;
      byte_q <= 3'd0;
      cmp_q  <= '0;
      rows_q <= 6'd0;
      op_q   <= 5'd0;
    end else if (start_acc) begin
      k_q    <= 3'd0;
      b_q    <= 3'd0;
      byte_q <= 3'd0;
      cmp_q  <= '0;
      rows_q <= cfg_rows;
      op_q   <= cfg_op;
    end else begin
      case (state_q)
        S_WGT: begin
          if (take) begin
            if (k_q == K_LAST) begin
              k_q <= 3'd0;
              b_q <= (b_q == B_LAST) ? 3'd0 : b_q + 3'd1;
            end else begin
              k_q <= k_q + 3'd1;
            end
          end
        end
        S_IMG_LO, S_IMG_HI: begin
          if (take) byte_q <= byte_q + 3'd1;
        end
        S_ROW: begin
          if (take) begin
            byte_q <= byte_q + 3'd1;
            if (byte_last) rows_q <= rows_q - 6'd1;
          end
        end
        S_COMPUTE: begin
          cmp_q <= cmp_last ? '0 : cmp_q + CMP_W'(1);
        end
        default: begin
          k_q <= k_q;
        end
      endcase
    end
  end

`ifdef BPUG_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall <= 16'd0;
    end else if (start_acc) begin
      perf_stall <= 16'd0;
    end else if (load_st && !s_valid && (perf_stall != 16'hFFFF)) begin
      perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bpug_sequencer.sv
// Self-checking bench for bpug_sequencer: table of runs checked against a word-list reference model.
module tb_bpug_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  cfg_rows;
  logic [4:0]  cfg_op;
  logic        cfg_sel;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [12:0] bpug_instr;
  logic [7:0]  bpug_data;
  logic        bpug_enable;
  logic        bpug_sel;
  logic        busy;
  logic        done;
`ifdef BPUG_SEQ_PERF_EN
  logic [15:0] perf_stall;
`endif

  always #5 clk = ~clk;

  bpug_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_op(cfg_op),
    .cfg_sel(cfg_sel), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .bpug_instr(bpug_instr), .bpug_data(bpug_data), .bpug_enable(bpug_enable),
    .bpug_sel(bpug_sel), .busy(busy), .done(done)
`ifdef BPUG_SEQ_PERF_EN
    , .perf_stall(perf_stall)
`endif
  );

  typedef struct {
    logic [12:0] instr;
    logic [7:0]  data;
    logic [7:0]  mask;
    bit          load;
  } word_t;

  typedef struct {
    int         rows;
    logic [4:0] op;
    logic       sel;
    int         validPct;
    bit         startNoise;
    int         stallAt;
    int         expWords;
    int         expStalls;
  } vec_t;

  int errors = 0;
  int checks = 0;

  word_t      words[$];
  logic [7:0] bytesQ[$];

  // Reference model: position in the expected word list plus the visible busy/done/sel state.
  bit          mActive = 0;
  int          mIdx = 0;
  int          byteIdx = 0;
  int          mStalls = 0;
  logic        mBusy = 0;
  logic        mDone = 0;
  logic        mSel = 0;
  logic [12:0] expInstr = 0;
  logic [7:0]  expData = 0;
  logic [7:0]  expMask = 8'hFF;
  logic        expEn = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void buildWords(input int rows, input logic [4:0] op);
    word_t w;
    int bi = 0;
    words.delete();
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < 7; k++) begin
        w.instr = 13'h040 | 13'(b << 10); w.data = bytesQ[bi]; w.mask = 8'h7F; w.load = 1;
        words.push_back(w); bi++;
      end
    for (int half = 0; half < 2; half++)
      for (int i = 0; i < 8; i++) begin
        w.instr = (half == 1) ? 13'h280 : 13'h080; w.data = bytesQ[bi]; w.mask = 8'hFF; w.load = 1;
        words.push_back(w); bi++;
      end
    for (int r = 0; r <= rows; r++) begin
      if (r > 0) begin
        w.instr = 13'h100; w.data = 0; w.mask = 8'hFF; w.load = 0;
        words.push_back(w);
        for (int i = 0; i < 8; i++) begin
          w.instr = 13'h080; w.data = bytesQ[bi]; w.mask = 8'hFF; w.load = 1;
          words.push_back(w); bi++;
        end
      end
      for (int p = 0; p < 2; p++)
        for (int c = 0; c < 2; c++) begin
          w.instr = 13'(p << 5) | 13'(op); w.data = 0; w.mask = 8'hFF; w.load = 0;
          words.push_back(w);
        end
    end
  endfunction

  // Decides what the coming edge must produce from the inputs currently driven.
  task automatic modelPredict();
    logic nextDone = 0;
    logic nextBusy;
    logic nextSel;
    bit   startAcc;
    checkOutput("s_ready", s_ready, mActive && words[mIdx].load);
    startAcc = !mActive && !mBusy && start;
    expInstr = 0; expData = 0; expMask = 8'hFF; expEn = 0;
    if (mActive) begin
      if (words[mIdx].load && !s_valid) begin
        mStalls++;
      end else begin
        expInstr = words[mIdx].instr; expData = words[mIdx].data;
        expMask = words[mIdx].mask; expEn = 1;
        if (words[mIdx].load) byteIdx++;
        mIdx++;
        if (mIdx == words.size()) begin
          nextDone = 1; mActive = 0;
        end
      end
    end
    nextBusy = startAcc ? 1'b1 : (mDone ? 1'b0 : mBusy);
    nextSel  = startAcc ? cfg_sel : (mDone ? 1'b0 : mSel);
    if (startAcc) begin
      mActive = 1; mIdx = 0; byteIdx = 0; mStalls = 0;
    end
    mBusy = nextBusy; mSel = nextSel; mDone = nextDone;
  endtask

  task automatic applyStimulus(input vec_t v);
    int  cyc = 0, seen = 0, doneAt = -1, nops = 0, stallLeft = 3;
    bit  finished = 0;
    bytesQ.delete();
    for (int i = 0; i < 72 + 8 * v.rows; i++) bytesQ.push_back(8'($urandom));
    buildWords(v.rows, v.op);
    start = 1; cfg_rows = 6'(v.rows); cfg_op = v.op; cfg_sel = v.sel;
    s_valid = 0; s_data = bytesQ[0];
    while (!finished) begin
      modelPredict();
      @(posedge clk);
      @(negedge clk);
      checkOutput("instr", bpug_instr, expInstr);
      checkOutput("data", bpug_data & expMask, expData & expMask);
      checkOutput("enable", bpug_enable, expEn);
      checkOutput("done", done, mDone);
      checkOutput("busy", busy, mBusy);
      checkOutput("sel", bpug_sel, mSel);
`ifdef BPUG_SEQ_PERF_EN
      checkOutput("perf_stall", perf_stall, mStalls);
`endif
      if (bpug_enable) seen++;
      if (done) doneAt = seen;
      if (busy && !bpug_enable) nops++;
      cyc++;
      if (!mActive && !mBusy) begin
        finished = 1;
      end else if (cyc >= 5000) begin
        checks++; errors++;
        $display("[TB] FAIL cycle budget: run still active after %0d cycles, required completion", cyc);
        finished = 1;
      end
      start    = v.startNoise && ($urandom_range(15) == 0);
      cfg_rows = 6'($urandom); cfg_op = 5'($urandom); cfg_sel = 1'($urandom);
      s_valid  = ($urandom_range(99) < v.validPct);
      if (v.stallAt >= 0 && mActive && mIdx == v.stallAt && stallLeft > 0) begin
        s_valid = 0; stallLeft--;
      end
      s_data = (byteIdx < bytesQ.size()) ? bytesQ[byteIdx] : 8'($urandom);
    end
    start = 0; s_valid = 0;
    checkOutput("word count", seen, v.expWords);
    checkOutput("done word", doneAt, v.expWords);
    if (v.expStalls >= 0) begin
      checkOutput("nop count", nops - 1, v.expStalls);
`ifdef BPUG_SEQ_PERF_EN
      checkOutput("perf_stall final", perf_stall, v.expStalls);
`endif
    end
  endtask

  task automatic checkResetIdle(input string tag);
    checkOutput({tag, " instr"}, bpug_instr, 0);
    checkOutput({tag, " data"}, bpug_data, 0);
    checkOutput({tag, " enable"}, bpug_enable, 0);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " done"}, done, 0);
    checkOutput({tag, " sel"}, bpug_sel, 0);
    checkOutput({tag, " s_ready"}, s_ready, 0);
`ifdef BPUG_SEQ_PERF_EN
    checkOutput({tag, " perf_stall"}, perf_stall, 0);
`endif
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{rows: 0,  op: 5'h15, sel: 1, validPct: 100, startNoise: 0, stallAt: -1, expWords: 76,  expStalls: 0};
    vecs[1] = '{rows: 0,  op: 5'h0A, sel: 0, validPct: 100, startNoise: 0, stallAt: 60, expWords: 76,  expStalls: 3};
    vecs[2] = '{rows: 2,  op: 5'h1F, sel: 1, validPct: 100, startNoise: 1, stallAt: -1, expWords: 102, expStalls: 0};
    vecs[3] = '{rows: 1,  op: 5'h03, sel: 0, validPct: 60,  startNoise: 1, stallAt: -1, expWords: 89,  expStalls: -1};
    vecs[4] = '{rows: 3,  op: 5'h11, sel: 1, validPct: 75,  startNoise: 0, stallAt: -1, expWords: 115, expStalls: -1};
    vecs[5] = '{rows: 63, op: 5'h07, sel: 1, validPct: 85,  startNoise: 1, stallAt: -1, expWords: 895, expStalls: -1};
    vecs[6] = '{rows: 2,  op: 5'h1C, sel: 0, validPct: 40,  startNoise: 1, stallAt: -1, expWords: 102, expStalls: -1};

    rst = 0; start = 0; cfg_rows = 0; cfg_op = 0; cfg_sel = 0; s_data = 0; s_valid = 0;
    @(negedge clk);
    checkResetIdle("reset");
    @(negedge clk);
    rst = 1;
    @(negedge clk);

    // Abandon a run partway through the weight phase with an asynchronous reset.
    start = 1; cfg_rows = 6'd2; cfg_op = 5'h09; cfg_sel = 1;
    @(negedge clk);
    start = 0; s_valid = 1;
    for (int i = 0; i < 10; i++) begin
      s_data = 8'($urandom);
      @(negedge clk);
    end
    checkOutput("pre-reset busy", busy, 1);
    rst = 0;
    #1;
    checkResetIdle("async reset");
    @(posedge clk);
    @(negedge clk);
    checkResetIdle("held reset");
    s_valid = 0;
    rst = 1;
    @(negedge clk);
    mActive = 0; mBusy = 0; mDone = 0; mSel = 0; mStalls = 0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
